// File: rtl/var_delay_line.sv
// var_delay_line: runtime-configurable delay line with valid tracking.
// Depth 0 passes a/in_valid straight through to b/out_valid.
//
// Ports:
//   clk, rst   rising-edge clock, async active-high reset
//   en         advance enable (0 holds every stage)
//   a/in_valid data in and its qualifier
//   flush      clear all stage valids (highest priority after rst)
//   load       take depth_in (clamped to MAX_DEPTH) as the active depth
//   depth_in   requested delay in cycles
//   b/out_valid delayed data and its qualifier
//   empty      no valid entry inside the active window
//   depth      active delay
//   cfg_err    sticky flag: a load asked for more than MAX_DEPTH
module var_delay_line #(
    parameter int WIDTH         = 4,
    parameter int MAX_DEPTH     = 8,
    parameter int DEFAULT_DEPTH = 3,
    localparam int DEPTH_W      = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [WIDTH-1:0]   a,
    input  logic               in_valid,
    input  logic               flush,
    input  logic               load,
    input  logic [DEPTH_W-1:0] depth_in,
    output logic [WIDTH-1:0]   b,
    output logic               out_valid,
    output logic               empty,
    output logic [DEPTH_W-1:0] depth,
    output logic               cfg_err
);

    localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] DEF_D = DEPTH_W'(DEFAULT_DEPTH);

    logic [WIDTH-1:0]     d [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] v;
    logic [DEPTH_W-1:0]   depth_q;
    logic                 over;
    logic                 any_v;

    assign over  = (depth_in > MAX_D);
    assign depth = depth_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                d[i] <= '0;
            end
            v       <= '0;
            depth_q <= DEF_D;
            cfg_err <= 1'b0;
        end else if (flush) begin
            v <= '0;
        end else if (load) begin
            // A reload always starts from an empty window, even
            // when the depth does not change.
            depth_q <= over ? MAX_D : depth_in;
            v       <= '0;
            if (over) begin
                cfg_err <= 1'b1;
            end
        end else if (en) begin
            // Every stage shifts; the tap below picks the output.
            d[0] <= a;
            v[0] <= in_valid;
            for (int i = 1; i < MAX_DEPTH; i++) begin
                d[i] <= d[i-1];
                v[i] <= v[i-1];
            end
        end
    end

    always_comb begin
        b         = '0;
        out_valid = 1'b0;
        any_v     = 1'b0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (depth_q == DEPTH_W'(i + 1)) begin
                b         = d[i];
                out_valid = v[i];
            end
            if (DEPTH_W'(i) < depth_q) begin
                any_v = any_v | v[i];
            end
        end
        empty = ~any_v;
        if (depth_q == '0) begin
            b         = a;
            out_valid = in_valid;
            empty     = 1'b1;
        end
    end

endmodule

// File: tb/tb_var_delay_line.sv
// tb_var_delay_line: directed checks of var_delay_line.
// WIDTH=8 so the 10..20 stream fits.
module tb_var_delay_line;

    localparam int W  = 8;
    localparam int MD = 8;
    localparam int DW = $clog2(MD + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [W-1:0]  a;
    logic          in_valid;
    logic          flush;
    logic          load;
    logic [DW-1:0] depth_in;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          empty;
    logic [DW-1:0] depth;
    logic          cfg_err;

    int total  = 0;
    int passed = 0;

    var_delay_line #(
        .WIDTH(W),
        .MAX_DEPTH(MD),
        .DEFAULT_DEPTH(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .a(a),
        .in_valid(in_valid),
        .flush(flush),
        .load(load),
        .depth_in(depth_in),
        .b(b),
        .out_valid(out_valid),
        .empty(empty),
        .depth(depth),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] o,
                         input logic [31:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, o, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; a = '0; in_valid = 1'b0;
        flush = 1'b0; load = 1'b0; depth_in = '0;
        #12;
        check("rst_b", 32'(b), 0);
        check("rst_ov", 32'(out_valid), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_depth", 32'(depth), 3);
        check("rst_cfg", 32'(cfg_err), 0);
        #8 rst = 1'b0;

        // stream at default depth 3
        for (int k = 1; k <= 8; k++) begin
            a = W'(k); in_valid = 1'b1;
            tick();
            check($sformatf("s1_ov%0d", k), 32'(out_valid),
                  (k >= 3) ? 1 : 0);
            check($sformatf("s1_b%0d", k), 32'(b),
                  (k >= 3) ? 32'(k - 2) : 0);
            if (k == 1) check("s1_empty", 32'(empty), 0);
        end

        // stall: reload depth 3 then stream with a 2-cycle hold
        load = 1'b1; depth_in = 3; tick(); load = 1'b0;
        check("st_depth", 32'(depth), 3);
        check("st_ov0", 32'(out_valid), 0);
        a = 1; tick(); check("st_ov1", 32'(out_valid), 0);
        a = 2; tick(); check("st_ov2", 32'(out_valid), 0);
        a = 3; tick(); check("st_b3", 32'(b), 1);
        check("st_ov3", 32'(out_valid), 1);
        en = 1'b0; a = 4;
        tick(); check("st_hold1", 32'(b), 1);
        check("st_hold1v", 32'(out_valid), 1);
        tick(); check("st_hold2", 32'(b), 1);
        en = 1'b1;
        tick(); check("st_b6", 32'(b), 2);
        in_valid = 1'b0; a = 0;
        tick(); check("st_b7", 32'(b), 3);
        tick(); check("st_b8", 32'(b), 4);
        check("st_ov8", 32'(out_valid), 1);
        tick(); check("st_ov9", 32'(out_valid), 0);
        check("st_empty9", 32'(empty), 1);

        // load depth 5, stream 10..20
        load = 1'b1; depth_in = 5; tick(); load = 1'b0;
        check("ld_depth", 32'(depth), 5);
        check("ld_empty", 32'(empty), 1);
        for (int j = 1; j <= 11; j++) begin
            a = W'(9 + j); in_valid = 1'b1;
            tick();
            check($sformatf("ld_ov%0d", j), 32'(out_valid),
                  (j >= 5) ? 1 : 0);
            if (j >= 5) check($sformatf("ld_b%0d", j), 32'(b), 32'(5 + j));
            if (j == 1) check("ld_empty1", 32'(empty), 0);
        end

        // depth 0: combinational bypass, independent of en
        load = 1'b1; depth_in = 0; tick(); load = 1'b0;
        check("d0_depth", 32'(depth), 0);
        a = 8'hA5; in_valid = 1'b1; #1;
        check("d0_b", 32'(b), 32'h A5);
        check("d0_ov", 32'(out_valid), 1);
        check("d0_empty", 32'(empty), 1);
        a = 8'h3C; in_valid = 1'b0; en = 1'b0; #1;
        check("d0_b2", 32'(b), 32'h3C);
        check("d0_ov2", 32'(out_valid), 0);
        en = 1'b1;
        tick();

        // clamp to MAX_DEPTH and sticky cfg_err
        load = 1'b1; depth_in = 12; tick(); load = 1'b0;
        check("cl_depth", 32'(depth), 8);
        check("cl_err", 32'(cfg_err), 1);
        for (int j = 1; j <= 8; j++) begin
            a = W'(8'h40 + j); in_valid = 1'b1;
            tick();
            if (j == 7) check("cl_ov7", 32'(out_valid), 0);
        end
        check("cl_ov8", 32'(out_valid), 1);
        check("cl_b8", 32'(b), 32'h41);
        load = 1'b1; depth_in = 2; tick(); load = 1'b0;
        check("cl_depth2", 32'(depth), 2);
        check("cl_err2", 32'(cfg_err), 1);

        // flush beats load beats en
        a = 8'h50; tick();
        a = 8'h51; tick();
        check("fl_pre_b", 32'(b), 32'h50);
        check("fl_pre_ov", 32'(out_valid), 1);
        flush = 1'b1; load = 1'b1; depth_in = 6; a = 8'h77;
        tick();
        flush = 1'b0; load = 1'b0;
        check("fl_depth", 32'(depth), 2);
        check("fl_ov", 32'(out_valid), 0);
        check("fl_empty", 32'(empty), 1);
        check("fl_noshift", 32'(b), 32'h50);

        // async reset between edges
        a = 8'h60; tick();
        a = 8'h61; tick();
        check("ar_pre_ov", 32'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("ar_b", 32'(b), 0);
        check("ar_ov", 32'(out_valid), 0);
        check("ar_depth", 32'(depth), 3);
        check("ar_cfg", 32'(cfg_err), 0);
        check("ar_empty", 32'(empty), 1);
        #2 rst = 1'b0;
        a = 8'h11; in_valid = 1'b1;
        tick(); tick(); tick();
        check("ar_post_b", 32'(b), 32'h11);
        check("ar_post_ov", 32'(out_valid), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
